fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 38 +++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: reset PC, bubble instruction,
// PC increment and the IF/ID pipeline bundle.
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset beats flush, flush beats stall.
module if_id_reg
    import rv32i_pkg::if_id_t;
    import rv32i_pkg::bubble;
#(
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t fetch_i,
    output if_id_t dec_o
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = fetch_i;
        if (flush) begin
            ifid_d = bubble(NOP_INSTR);
        end else if (stall) begin
            ifid_d = ifid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= bubble(NOP_INSTR);
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign dec_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select and the IF/ID register.
module fetch_stage
    import rv32i_pkg::if_id_t;
    import rv32i_pkg::PC_INC;
#(
    parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    logic [31:0] pc_fetch_q;
    logic [31:0] pc_fetch_d;
    logic [31:0] pc_plus4_f;
    if_id_t      fetch_bundle;
    if_id_t      dec_bundle;

    assign pc_plus4_f = pc_fetch_q + PC_INC;

    // Redirect wins over a fetch stall; targets are forced word-aligned.
    always_comb begin
        pc_fetch_d = pc_plus4_f;
        if (pc_src_e) begin
            pc_fetch_d = {pc_target_e[31:2], 2'b00};
        end else if (stall_f) begin
            pc_fetch_d = pc_fetch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_fetch_q <= RESET_PC;
        end else begin
            pc_fetch_q <= pc_fetch_d;
        end
    end

    assign pc_f      = pc_fetch_q;
    assign imem_addr = {2'b00, pc_fetch_q[31:2]};

    always_comb begin
        fetch_bundle.instr    = imem_rd;
        fetch_bundle.pc       = pc_fetch_q;
        fetch_bundle.pc_plus4 = pc_plus4_f;
        fetch_bundle.valid    = 1'b1;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_d),
        .stall   (stall_d),
        .fetch_i (fetch_bundle),
        .dec_o   (dec_bundle)
    );

    assign instr_d    = dec_bundle.instr;
    assign pc_d       = dec_bundle.pc;
    assign pc_plus4_d = dec_bundle.pc_plus4;
    assign valid_d    = dec_bundle.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rd;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    logic [31:0] imem_addr_b, imem_rd_b;
    logic [31:0] pc_f_b, instr_d_b, pc_d_b, pc_plus4_d_b;
    logic        valid_d_b;
    logic        zero_b = 1'b0;
    logic [31:0] zero32_b = 32'h0;

    logic [31:0] mem [0:5];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a < 32'd6) return mem[a[2:0]];
        return 32'hBAD0_0000 | {16'h0, a[15:0]};
    endfunction

    always_comb imem_rd   = mem_rd(imem_addr);
    always_comb imem_rd_b = mem_rd(imem_addr_b);

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (zero_b),
        .stall_d     (zero_b),
        .flush_d     (zero_b),
        .pc_src_e    (zero_b),
        .pc_target_e (zero32_b),
        .imem_addr   (imem_addr_b),
        .imem_rd     (imem_rd_b),
        .pc_f        (pc_f_b),
        .instr_d     (instr_d_b),
        .pc_d        (pc_d_b),
        .pc_plus4_d  (pc_plus4_d_b),
        .valid_d     (valid_d_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0030_0193;
        mem[3] = 32'h0040_0213;
        mem[4] = 32'h0050_0293;
        mem[5] = 32'h0060_0313;

        rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0;
        pc_src_e = 0; pc_target_e = 32'h0;

        step();
        chk("rst1_valid", {31'h0, valid_d}, 32'h0);
        step();
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_valid", {31'h0, valid_d}, 32'h0);
        chk("rst_pc_d", pc_d, 32'h0);
        chk("wrap_rst_pc", pc_f_b, 32'hFFFF_FFFC);
        rst = 1'b0;

        step();
        chk("run_pc4", pc_f, 32'h4);
        chk("run_instr0", instr_d, mem[0]);
        chk("run_pc_d0", pc_d, 32'h0);
        chk("run_pc4_d0", pc_plus4_d, 32'h4);
        chk("run_valid", {31'h0, valid_d}, 32'h1);
        chk("wrap_pc", pc_f_b, 32'h0);
        chk("wrap_pc_d", pc_d_b, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc_plus4_d_b, 32'h0);
        chk("wrap_instr", instr_d_b, 32'hBAD0_FFFF);

        step();
        chk("run_pc8", pc_f, 32'h8);
        chk("run_instr1", instr_d, mem[1]);

        stall_f = 1; stall_d = 1;
        step();
        chk("stall1_pc", pc_f, 32'h8);
        chk("stall1_instr", instr_d, mem[1]);
        step();
        chk("stall2_pc", pc_f, 32'h8);
        chk("stall2_instr", instr_d, mem[1]);
        stall_f = 0; stall_d = 0;

        step();
        chk("resume_pc", pc_f, 32'hC);
        chk("resume_instr", instr_d, mem[2]);
        chk("resume_pc_d", pc_d, 32'h8);

        pc_src_e = 1; pc_target_e = 32'h14; flush_d = 1;
        step();
        chk("br_pc", pc_f, 32'h14);
        chk("br_instr", instr_d, NOP);
        chk("br_valid", {31'h0, valid_d}, 32'h0);
        chk("br_pc_d", pc_d, 32'h0);
        pc_src_e = 0; flush_d = 0;

        step();
        chk("br_next_instr", instr_d, mem[5]);
        chk("br_next_pc_d", pc_d, 32'h14);
        chk("br_next_pc", pc_f, 32'h18);

        pc_src_e = 1; stall_f = 1; pc_target_e = 32'h4;
        step();
        chk("prio_redir_pc", pc_f, 32'h4);
        pc_src_e = 0; stall_f = 0;

        flush_d = 1; stall_d = 1;
        step();
        chk("prio_flush_instr", instr_d, NOP);
        chk("prio_flush_valid", {31'h0, valid_d}, 32'h0);
        chk("prio_flush_pc", pc_f, 32'h8);
        flush_d = 0; stall_d = 0;

        pc_src_e = 1; pc_target_e = 32'h17;
        step();
        chk("mask_pc", pc_f, 32'h14);
        chk("mask_instr", instr_d, mem[2]);
        pc_src_e = 0;

        stall_f = 1;
        step();
        chk("dup1_pc", pc_f, 32'h14);
        chk("dup1_instr", instr_d, mem[5]);
        step();
        chk("dup2_instr", instr_d, mem[5]);
        chk("dup2_pc_d", pc_d, 32'h14);

        rst = 1; pc_src_e = 1; pc_target_e = 32'h20; flush_d = 0;
        step();
        chk("rstredir_pc", pc_f, 32'h0);
        chk("rstredir_valid", {31'h0, valid_d}, 32'h0);
        chk("rstredir_instr", instr_d, NOP);
        rst = 0; pc_src_e = 0; stall_f = 0;

        step();
        chk("post_rst_pc", pc_f, 32'h4);
        chk("post_rst_instr", instr_d, mem[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
